enc_debounce_multi: RTL and testbench

- Parametrised multi-channel successor to the single-channel encoder noise filter.
- Synchronises N raw encoder/switch inputs and rejects glitches shorter than a programmable stability window.
- Per channel, emits debounced levels, one-cycle edge pulses and a per-channel edge event counter (saturating or wrapping).
- Sits between board pins and the control/display logic.

---
 rtl/enc_debounce_multi.sv | 94 +++++++++
 tb/tb_enc_debounce_multi.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_debounce_multi.sv
// Multi-channel encoder/switch debouncer with edge pulses and event counters.
// Each channel: 2-FF sync, stability window filter, saturating or wrapping counter.
module enc_debounce_multi #(
    parameter int CH         = 4,
    parameter int STABLE_CYC = 16,
    parameter int CNT_W      = 16,
    parameter int EDGE_MODE  = 0,
    parameter int WRAP       = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       enc,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       level,
    output logic [CH-1:0]       rise,
    output logic [CH-1:0]       fall,
    output logic [CH*CNT_W-1:0] cnt,
    output logic [CH-1:0]       ovf
);

    localparam int SW = $clog2(STABLE_CYC) + 1;
    localparam logic [SW-1:0] LAST = SW'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] PRE = MAX - 1'b1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic             s1_q;
        logic             s2_q;
        logic [SW-1:0]    stab_q;
        logic             lvl_q;
        logic             rise_q;
        logic             fall_q;
        logic [CNT_W-1:0] cnt_q;
        logic             ovf_q;
        logic             ev;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                s1_q   <= 1'b0;
                s2_q   <= 1'b0;
                stab_q <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                s1_q   <= enc[i];
                s2_q   <= s1_q;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (s2_q == lvl_q) begin
                    stab_q <= '0;
                end else if (stab_q == LAST) begin
                    lvl_q  <= s2_q;
                    stab_q <= '0;
                    rise_q <= s2_q;
                    fall_q <= ~s2_q;
                end else begin
                    stab_q <= stab_q + 1'b1;
                end
            end
        end

        // Counter follows the registered pulse, so it lags the pulse by a cycle.
        assign ev = (EDGE_MODE == 0) ? rise_q :
                    (EDGE_MODE == 1) ? fall_q : (rise_q | fall_q);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (clr[i]) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else if (ev) begin
                if (cnt_q == MAX) begin
                    if (WRAP != 0) begin
                        cnt_q <= '0;
                        ovf_q <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                    if (WRAP == 0 && cnt_q == PRE) ovf_q <= 1'b1;
                end
            end
        end

        assign level[i]              = lvl_q;
        assign rise[i]               = rise_q;
        assign fall[i]               = fall_q;
        assign ovf[i]                = ovf_q;
        assign cnt[i*CNT_W +: CNT_W] = cnt_q;
    end

endmodule

// File: tb/tb_enc_debounce_multi.sv
// Bench for enc_debounce_multi: scoreboard of expected edge pulses plus
// directed checks of level, counters and overflow on two configurations.
module tb_enc_debounce_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  enc = '0;
    logic [3:0]  clr = '0;
    logic [3:0]  level_a, rise_a, fall_a, ovf_a;
    logic [3:0]  level_b, rise_b, fall_b, ovf_b;
    logic [11:0] cnt_a, cnt_b;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;

    ev_t qa[$];
    ev_t qb[$];

    // a: rising-only, saturating; b: both edges, wrapping
    enc_debounce_multi #(
        .CH(4), .STABLE_CYC(16), .CNT_W(3), .EDGE_MODE(0), .WRAP(0)
    ) dut_a (
        .clk(clk), .rst(rst), .enc(enc), .clr(clr),
        .level(level_a), .rise(rise_a), .fall(fall_a),
        .cnt(cnt_a), .ovf(ovf_a)
    );

    enc_debounce_multi #(
        .CH(4), .STABLE_CYC(16), .CNT_W(3), .EDGE_MODE(2), .WRAP(1)
    ) dut_b (
        .clk(clk), .rst(rst), .enc(enc), .clr(clr),
        .level(level_b), .rise(rise_b), .fall(fall_b),
        .cnt(cnt_b), .ovf(ovf_b)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Change enc after an edge; expected pulses land 18 edges later.
    task automatic drive(input logic [3:0] v);
        ev_t e;
        e.r = v & ~enc;
        e.f = ~v & enc;
        e.cyc = cyc + 18;
        enc = v;
        if ((e.r | e.f) != 4'h0) begin
            qa.push_back(e);
            qb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rst && (rise_a | fall_a) != 4'h0) begin
            tests++;
            if (qa.size() == 0) begin
                failed++;
                $display("FAIL pulse_a: got cyc=%0d r=%b f=%b want none",
                         cyc, rise_a, fall_a);
            end else begin
                e = qa.pop_front();
                if (e.cyc != cyc || e.r !== rise_a || e.f !== fall_a) begin
                    failed++;
                    $display("FAIL pulse_a: got cyc=%0d r=%b f=%b want cyc=%0d r=%b f=%b",
                             cyc, rise_a, fall_a, e.cyc, e.r, e.f);
                end
            end
        end
        if (rst && (rise_b | fall_b) != 4'h0) begin
            tests++;
            if (qb.size() == 0) begin
                failed++;
                $display("FAIL pulse_b: got cyc=%0d r=%b f=%b want none",
                         cyc, rise_b, fall_b);
            end else begin
                e = qb.pop_front();
                if (e.cyc != cyc || e.r !== rise_b || e.f !== fall_b) begin
                    failed++;
                    $display("FAIL pulse_b: got cyc=%0d r=%b f=%b want cyc=%0d r=%b f=%b",
                             cyc, rise_b, fall_b, e.cyc, e.r, e.f);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ev_t e;
        // reset held, inputs toggling
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enc = 4'($urandom);
            tick(1);
            if (i % 3 == 0) begin
                chk("rst_out_a", {level_a, rise_a, fall_a, ovf_a, cnt_a}, 0);
                chk("rst_out_b", {level_b, rise_b, fall_b, ovf_b, cnt_b}, 0);
            end
        end
        enc = 4'h0;
        tick(3);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(10);
            chk("idle_a", {level_a, rise_a, fall_a, ovf_a, cnt_a}, 0);
        end
        chk("idle_b", {level_b, rise_b, fall_b, ovf_b, cnt_b}, 0);

        // noise: 5-cycle alternating pulses on enc[0], ends low
        for (int k = 0; k < 8; k++) begin
            enc[0] = ~enc[0];
            tick(5);
        end
        tick(30);
        chk("noise_lvl_a", level_a, 4'h0);
        chk("noise_cnt_b", cnt_b, 0);

        // clean step up then down
        drive(4'h1);
        tick(40);
        chk("step_lvl", level_a, 4'h1);
        chk("step_cnt_a", cnt_a, 12'h001);
        chk("step_cnt_b", cnt_b, 12'h001);
        tick(60);
        drive(4'h0);
        tick(40);
        chk("fall_lvl", level_a, 4'h0);
        chk("fall_cnt_a", cnt_a, 12'h001);
        chk("fall_cnt_b", cnt_b, 12'h002);

        // saturation / wrap with 9 rising edges
        clr = 4'hf;
        tick(1);
        clr = 4'h0;
        chk("clr_cnt_a", cnt_a, 0);
        chk("clr_cnt_b", cnt_b, 0);
        for (int k = 0; k < 9; k++) begin
            drive(4'h1);
            tick(25);
            drive(4'h0);
            tick(25);
        end
        chk("sat_cnt_a", cnt_a, 12'h007);
        chk("sat_ovf_a", ovf_a, 4'h1);
        chk("wrap_cnt_b", cnt_b, 12'h002);
        chk("wrap_ovf_b", ovf_b, 4'h1);

        // clear coincident with a counted rise
        drive(4'h1);
        tick(18);
        chk("rise_now", rise_a, 4'h1);
        clr = 4'h1;
        tick(1);
        clr = 4'h0;
        chk("cclr_cnt_a", cnt_a, 0);
        chk("cclr_ovf_a", ovf_a, 4'h0);
        chk("cclr_cnt_b", cnt_b, 0);
        chk("cclr_ovf_b", ovf_b, 4'h0);
        tick(10);
        chk("cclr_hold_b", cnt_b, 0);
        drive(4'h0);
        tick(25);
        chk("cclr_fall_b", cnt_b, 12'h001);
        chk("cclr_fall_a", cnt_a, 0);

        // all channels together, then noise on enc[1] only
        clr = 4'hf;
        tick(1);
        clr = 4'h0;
        drive(4'hf);
        tick(25);
        chk("multi_cnt_a", cnt_a, 12'h249);
        chk("multi_cnt_b", cnt_b, 12'h249);
        enc[1] = 1'b0;
        tick(5);
        enc[1] = 1'b1;
        tick(5);
        enc[1] = 1'b0;
        tick(3);
        enc[1] = 1'b1;
        tick(30);
        chk("n1_lvl_a", level_a, 4'hf);
        chk("n1_cnt_a", cnt_a, 12'h249);
        drive(4'h0);
        tick(25);
        chk("multi_fall_b", cnt_b, 12'h492);
        chk("multi_fall_a", cnt_a, 12'h249);

        // reset in the middle of a stability window
        enc = 4'h4;
        tick(10);
        rst = 1'b0;
        tick(1);
        chk("mid_rst_a", {level_a, rise_a, fall_a, ovf_a, cnt_a}, 0);
        rst = 1'b1;
        e.cyc = cyc + 18;
        e.r = 4'h4;
        e.f = 4'h0;
        qa.push_back(e);
        qb.push_back(e);
        tick(17);
        chk("mid_early", level_a, 4'h0);
        tick(8);
        chk("mid_lvl", level_a, 4'h4);
        chk("mid_cnt_a", cnt_a, 12'h040);
        chk("mid_cnt_b", cnt_b, 12'h040);

        drive(4'h0);
        tick(30);
        chk("q_a_empty", qa.size(), 0);
        chk("q_b_empty", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
